// File: rtl/xy_switch_rr_pkg.sv
// Shared port indices and the XY routing function for the round-robin mesh switch.
package xy_switch_rr_pkg;

    localparam int PORT_RES   = 0;
    localparam int PORT_N_IDX = 1;
    localparam int PORT_E     = 2;
    localparam int PORT_S     = 3;
    localparam int PORT_W     = 4;

    // X is resolved completely before Y, which keeps the mesh deadlock-free.
    function automatic int xy_route(
        input int unsigned dst_x,
        input int unsigned dst_y,
        input int unsigned x_cord,
        input int unsigned y_cord
    );
        if (dst_x > x_cord)      return PORT_E;
        else if (dst_x < x_cord) return PORT_W;
        else if (dst_y > y_cord) return PORT_N_IDX;
        else if (dst_y < y_cord) return PORT_S;
        else                     return PORT_RES;
    endfunction

endpackage

// File: rtl/xy_switch_rr_rr_arbiter.sv
// Round-robin arbiter for one switch output: one-hot grant from a rotating priority pointer.
module rr_arbiter #(
    parameter int PORT_N = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [PORT_N-1:0] req,
    input  logic              en,
    output logic [PORT_N-1:0] gnt
);

    localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_nxt_ptr;
    logic             w_found;

    always_comb begin
        gnt       = '0;
        w_found   = 1'b0;
        w_nxt_ptr = r_ptr;
        for (int k = 0; k < PORT_N; k++) begin
            if (!w_found && en && req[(int'(r_ptr) + k) % PORT_N]) begin
                gnt[(int'(r_ptr) + k) % PORT_N] = 1'b1;
                w_found   = 1'b1;
                w_nxt_ptr = PTR_W'((int'(r_ptr) + k + 1) % PORT_N);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_nxt_ptr;
        end
    end

endmodule

// File: rtl/xy_switch_rr.sv
// Mesh XY switch with per-input FIFOs, per-output round-robin arbiters and registered outputs.
// Define XY_SWITCH_RR_STATS_EN to add per-output forwarded-packet counters on pckt_cnt_o.
module xy_switch_rr
    import xy_switch_rr_pkg::*;
#(
    parameter int unsigned X_CORD          = 0,
    parameter int unsigned Y_CORD          = 0,
    parameter int          PORT_N          = 5,
    parameter int          IN_FIFO_DEPTH_W = 3,
    parameter int          PCKT_XADDR_W    = 4,
    parameter int          PCKT_YADDR_W    = 4,
    parameter int          PCKT_DATA_W     = 8,
    parameter int          PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PORT_N-1:0]        wr_en_sw_i,
    input  logic [PCKT_W*PORT_N-1:0] pckt_sw_i,
    output logic [PORT_N-1:0]        in_fifo_full_o,
    output logic [PORT_N-1:0]        in_fifo_overflow_o,
    input  logic [PORT_N-1:0]        nxt_fifo_full_i,
    input  logic [PORT_N-1:0]        nxt_fifo_overflow_i,
    output logic [PORT_N-1:0]        wr_en_sw_o,
    output logic [PCKT_W*PORT_N-1:0] pckt_sw_o,
    output logic                     err_o
`ifdef XY_SWITCH_RR_STATS_EN
    ,
    output logic [32*PORT_N-1:0]     pckt_cnt_o
`endif
);

    localparam int             AW        = IN_FIFO_DEPTH_W;
    localparam int             D         = 1 << AW;
    localparam logic [AW:0]    CNT_FULL  = (AW+1)'(D);
    localparam logic [AW:0]    CNT_AFULL = (AW+1)'(D - 1);

    logic [PORT_N-1:0][PCKT_W-1:0] w_head;
    logic [PORT_N-1:0]             w_valid;
    logic [PORT_N-1:0]             w_pop;
    logic [PORT_N-1:0][PORT_N-1:0] w_req;
    logic [PORT_N-1:0][PORT_N-1:0] w_gnt;
    logic [PORT_N-1:0][PCKT_W-1:0] w_sel;

    logic [PORT_N-1:0]             r_wr_en;
    logic [PORT_N-1:0][PCKT_W-1:0] r_pckt;
    logic                          r_err;

    for (genvar gi = 0; gi < PORT_N; gi++) begin : g_fifo
        logic [PCKT_W-1:0] r_mem [D];
        logic [AW-1:0]     r_rd_ptr;
        logic [AW-1:0]     r_wr_ptr;
        logic [AW:0]       r_cnt;
        logic              r_ovf;
        logic              w_push;

        // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
        assign w_push = wr_en_sw_i[gi] && ((r_cnt != CNT_FULL) || w_pop[gi]);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
            end else begin
                if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop[gi]) r_rd_ptr <= r_rd_ptr + 1'b1;
                case ({w_push, w_pop[gi]})
                    2'b10:   r_cnt <= r_cnt + 1'b1;
                    2'b01:   r_cnt <= r_cnt - 1'b1;
                    default: r_cnt <= r_cnt;
                endcase
                r_ovf <= wr_en_sw_i[gi] && !w_push;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_push) r_mem[r_wr_ptr] <= pckt_sw_i[PCKT_W*gi +: PCKT_W];
        end

        assign w_head[gi]             = r_mem[r_rd_ptr];
        assign w_valid[gi]            = (r_cnt != '0);
        assign in_fifo_full_o[gi]     = (r_cnt >= CNT_AFULL);
        assign in_fifo_overflow_o[gi] = r_ovf;
    end

    always_comb begin
        w_req = '0;
        for (int i = 0; i < PORT_N; i++) begin
            if (w_valid[i]) begin
                w_req[xy_route(32'(w_head[i][PCKT_W-1 -: PCKT_XADDR_W]),
                               32'(w_head[i][PCKT_DATA_W+PCKT_YADDR_W-1 -: PCKT_YADDR_W]),
                               X_CORD, Y_CORD)][i] = 1'b1;
            end
        end
    end

    for (genvar go = 0; go < PORT_N; go++) begin : g_arb
        rr_arbiter #(.PORT_N(PORT_N)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req   (w_req[go]),
            .en    (!nxt_fifo_full_i[go]),
            .gnt   (w_gnt[go])
        );
    end

    // Each input requests a single output, so at most one grant per column.
    always_comb begin
        w_pop = '0;
        w_sel = '0;
        for (int o = 0; o < PORT_N; o++) begin
            w_pop = w_pop | w_gnt[o];
            for (int i = 0; i < PORT_N; i++) begin
                if (w_gnt[o][i]) w_sel[o] = w_head[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_en <= '0;
            r_pckt  <= '0;
            r_err   <= 1'b0;
        end else begin
            for (int o = 0; o < PORT_N; o++) begin
                r_wr_en[o] <= |w_gnt[o];
                if (|w_gnt[o]) r_pckt[o] <= w_sel[o];
            end
            r_err <= r_err | (|nxt_fifo_overflow_i);
        end
    end

    assign wr_en_sw_o = r_wr_en;
    assign pckt_sw_o  = r_pckt;
    assign err_o      = r_err;

`ifdef XY_SWITCH_RR_STATS_EN
    logic [PORT_N-1:0][31:0] r_pckt_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pckt_cnt <= '0;
        end else begin
            for (int o = 0; o < PORT_N; o++) begin
                if (r_wr_en[o]) r_pckt_cnt[o] <= r_pckt_cnt[o] + 32'd1;
            end
        end
    end

    assign pckt_cnt_o = r_pckt_cnt;
`endif

endmodule
